word_mismatch_monitor: RTL and testbench
========================================

# word_mismatch_monitor

Registered consumer stage that accepts pairs of W-bit words over a valid/ready handshake, compares them bit-by-bit with the team's XOR/OR inequality function, and tracks mismatch history. It sits directly downstream of the combinational word-inequality comparator. It adds a one-cycle registered result, a saturating mismatch counter, a consecutive-mismatch run tracker and a sticky alarm that back-pressures the producer.

## Interface
- W, 6, word width in bits
- CNT_W, 8, width of mismatch counter
- RUN_LIM, 3, consecutive mismatches that raise alarm (1..15)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer has a word pair
- in_ready  out  1  block can accept; transfer when in_valid & in_ready
- in_a  in  W  first word
- in_b  in  W  second word
- clear  in  1  synchronous clear of counter, run and alarm
- neq_valid  out  1  one-cycle pulse, result registers updated
- neq  out  1  1 when accepted a != b
- diff_mask  out  W  registered a ^ b of last accepted pair
- diff_bits  out  clog2(W+1)  popcount of diff_mask (see Configuration)
- mismatch_count  out  CNT_W  saturating total of mismatches
- run_len  out  4  current consecutive-mismatch run, saturates at 15
- alarm  out  1  sticky, run_len reached RUN_LIM

## Operation
- Reset: the single clock is clk; reset is asynchronous, active-low (rst_n). All outputs 0, except in_ready, which is 1. State is IDLE.
- FSM states are IDLE, MATCH, MISM, ALARM.
  - IDLE: no transfer accepted since reset/clear.
  - Equal transfer from any non-ALARM state -> MATCH; run_len <= 0.
  - Unequal transfer -> MISM; run_len += 1 (saturating at 15); mismatch_count += 1 (saturating at 2^CNT_W-1).
  - In MISM, if run_len+1 >= RUN_LIM on an unequal transfer -> ALARM and alarm <= 1.
- ALARM: in_ready = 0, so no transfers are accepted; outputs hold. Exit only via clear or reset.
- clear (any state) -> IDLE next cycle. mismatch_count, run_len, alarm, neq and diff_mask all go to 0. in_ready returns to 1.
  - If clear coincides with a transfer, clear wins and the transfer is accepted but discarded: no neq_valid.
- in_ready = (state != ALARM). It is combinational from state only, never from in_valid.
- The comparison is neq = |(in_a ^ in_b), same function as the upstream comparator. diff_mask = in_a ^ in_b.
- The transfer that raises alarm still produces a neq_valid pulse and updates the count.

## Timing
- Latency 1: a transfer at edge N gives neq_valid=1 and updated neq/diff_mask/count/run_len/alarm after edge N. These are visible in cycle N+1.
- neq_valid is high for exactly one cycle per accepted transfer. Back-to-back transfers produce back-to-back pulses, with full throughput of 1 word/cycle.
- in_ready drops in the cycle after the alarming transfer.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- in_a and in_b are sampled only on transfer edges. Their values are don't-care otherwise.

## Configuration
- GUIA08_POPCOUNT_EN:
  - Defined: diff_bits is a registered popcount of in_a ^ in_b, updated with neq_valid and cleared by reset/clear.
  - Undefined: the popcount logic is absent and diff_bits is tied to 0.
  - The port list is identical in both cases.

## Structure
- The shared package/header holds:
  - FSM state encodings: IDLE=2'd0, MATCH=2'd1, MISM=2'd2, ALARM=2'd3.
  - Default W=6, CNT_W=8, RUN_LIM=3.
  - The run_len width constant (4).
- One sub-module, word_neq_cmp: parameterised combinational W-bit XOR/OR inequality, outputs neq and diff_mask. It is instantiated once. All registers and the FSM live in the top.

## Test plan
- Reset: hold rst_n=0 -> all outputs 0, in_ready=1. Release, with in_valid=0 for 5 cycles -> nothing changes.
- Equal pair a=b=6'b110110 -> one cycle later neq_valid=1, neq=0, diff_mask=0, count=0, state MATCH.
- Pair a=6'b110110, b=6'b101010 -> neq=1, diff_mask=6'b011100, count=1, run_len=1; diff_bits=3 with GUIA08_POPCOUNT_EN, else 0.
- Three back-to-back unequal pairs -> run_len 1,2,3. alarm=1 after the third, in_ready=0 next cycle. A fourth pair held valid is not accepted and count stays 3. clear -> count=0, alarm=0, in_ready=1.
- Saturation: CNT_W=2 override with 5 unequal pairs interleaved with equal pairs (no alarm) -> count sticks at 3. An equal pair resets run_len to 0.
- Async reset asserted between edges while in ALARM -> outputs 0 immediately. clear coincident with a transfer -> no neq_valid, state IDLE.

Source files
------------

// File: rtl/word_mismatch_monitor_pkg.sv
// ============================================================================
// Module : word_mismatch_monitor_pkg
// Brief  : Shared FSM encodings, default parameters and run-length constants
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package word_mismatch_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_MISM  = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int DEF_W       = 6;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_RUN_LIM = 3;

  localparam int                RUN_W   = 4;
  localparam logic [RUN_W-1:0]  RUN_MAX = 4'hF;

endpackage

`default_nettype wire

// File: rtl/word_mismatch_monitor_neq_cmp.sv
// ============================================================================
// Module : word_neq_cmp
// Brief  : Combinational W-bit XOR/OR inequality comparator with diff mask
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_neq_cmp #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_neq,
  output logic [W-1:0] o_diff_mask
);

  assign o_diff_mask = i_a ^ i_b;
  assign o_neq       = |o_diff_mask;

endmodule

`default_nettype wire

// File: rtl/word_mismatch_monitor.sv
// ============================================================================
// Module : word_mismatch_monitor
// Brief  : Registered word-pair mismatch monitor with saturating count, run
//          tracker and sticky back-pressuring alarm. Optional popcount output
//          enabled by macro GUIA08_POPCOUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_mismatch_monitor
  import word_mismatch_monitor_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RUN_LIM = DEF_RUN_LIM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [W-1:0]           i_in_a,
  input  logic [W-1:0]           i_in_b,
  input  logic                   i_clear,
  output logic                   o_neq_valid,
  output logic                   o_neq,
  output logic [W-1:0]           o_diff_mask,
  output logic [$clog2(W+1)-1:0] o_diff_bits,
  output logic [CNT_W-1:0]       o_mismatch_count,
  output logic [RUN_W-1:0]       o_run_len,
  output logic                   o_alarm
);

  localparam int               DB_W      = $clog2(W+1);
  localparam logic [RUN_W-1:0] c_run_lim = RUN_W'(RUN_LIM);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_ready;
  logic             w_xfer;
  logic             w_neq;
  logic [W-1:0]     w_diff_mask;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_cnt_sat;

  logic             r_neq_valid;
  logic             r_neq;
  logic [W-1:0]     r_diff_mask;
  logic [CNT_W-1:0] r_count;
  logic [RUN_W-1:0] r_run_len;
  logic             r_alarm;

  word_neq_cmp #(
    .W (W)
  ) u_cmp (
    .i_a         (i_in_a),
    .i_b         (i_in_b),
    .o_neq       (w_neq),
    .o_diff_mask (w_diff_mask)
  );

  // Ready depends on state alone so the producer never sees a valid->ready loop.
  assign w_ready   = (r_state != ST_ALARM);
  assign w_xfer    = i_in_valid & w_ready;
  assign w_run_inc = (r_run_len == RUN_MAX) ? r_run_len : r_run_len + 1'b1;
  assign w_cnt_sat = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = ST_IDLE;
    end else if (w_xfer) begin
      if (!w_neq) begin
        w_next_state = ST_MATCH;
      end else if (w_run_inc >= c_run_lim) begin
        w_next_state = ST_ALARM;
      end else begin
        w_next_state = ST_MISM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neq_valid <= 1'b0;
      r_neq       <= 1'b0;
      r_diff_mask <= '0;
      r_count     <= '0;
      r_run_len   <= '0;
      r_alarm     <= 1'b0;
    end else begin
      // A transfer coinciding with clear is consumed but produces no result.
      r_neq_valid <= w_xfer & ~i_clear;
      if (i_clear) begin
        r_neq       <= 1'b0;
        r_diff_mask <= '0;
        r_count     <= '0;
        r_run_len   <= '0;
        r_alarm     <= 1'b0;
      end else if (w_xfer) begin
        r_neq       <= w_neq;
        r_diff_mask <= w_diff_mask;
        if (w_neq) begin
          r_run_len <= w_run_inc;
          if (!w_cnt_sat) begin
            r_count <= r_count + 1'b1;
          end
          if (w_run_inc >= c_run_lim) begin
            r_alarm <= 1'b1;
          end
        end else begin
          r_run_len <= '0;
        end
      end
    end
  end

`ifdef GUIA08_POPCOUNT_EN
  logic [DB_W-1:0] w_popcnt;
  logic [DB_W-1:0] r_diff_bits;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < W; i++) begin
      w_popcnt = w_popcnt + DB_W'(w_diff_mask[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_bits <= '0;
    end else if (i_clear) begin
      r_diff_bits <= '0;
    end else if (w_xfer) begin
      r_diff_bits <= w_popcnt;
    end
  end

  assign o_diff_bits = r_diff_bits;
`else
  assign o_diff_bits = {DB_W{1'b0}};
`endif

  assign o_in_ready       = w_ready;
  assign o_neq_valid      = r_neq_valid;
  assign o_neq            = r_neq;
  assign o_diff_mask      = r_diff_mask;
  assign o_mismatch_count = r_count;
  assign o_run_len        = r_run_len;
  assign o_alarm          = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_word_mismatch_monitor.sv
// ============================================================================
// Module : tb_word_mismatch_monitor
// Brief  : Self-checking bench for word_mismatch_monitor (default and CNT_W=2)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_word_mismatch_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] in_a = '0;
  logic [5:0] in_b = '0;

  logic       in_ready, neq_valid, neq, alarm;
  logic [5:0] diff_mask;
  logic [2:0] diff_bits;
  logic [7:0] mcount;
  logic [3:0] run_len;

  logic       in_ready2, neq_valid2, neq2, alarm2;
  logic [5:0] diff_mask2;
  logic [2:0] diff_bits2;
  logic [1:0] mcount2;
  logic [3:0] run_len2;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit       m_alarm;
  int       m_run, m_count, m_count2, m_bits;
  bit       m_valid, m_neq;
  bit [5:0] m_mask;

  always #5 clk = ~clk;

  word_mismatch_monitor dut (
    .clk (clk), .rst_n (rst_n), .i_in_valid (in_valid), .o_in_ready (in_ready),
    .i_in_a (in_a), .i_in_b (in_b), .i_clear (clear), .o_neq_valid (neq_valid),
    .o_neq (neq), .o_diff_mask (diff_mask), .o_diff_bits (diff_bits),
    .o_mismatch_count (mcount), .o_run_len (run_len), .o_alarm (alarm)
  );

  word_mismatch_monitor #(.W(6), .CNT_W(2), .RUN_LIM(3)) dut2 (
    .clk (clk), .rst_n (rst_n), .i_in_valid (in_valid), .o_in_ready (in_ready2),
    .i_in_a (in_a), .i_in_b (in_b), .i_clear (clear), .o_neq_valid (neq_valid2),
    .o_neq (neq2), .o_diff_mask (diff_mask2), .o_diff_bits (diff_bits2),
    .o_mismatch_count (mcount2), .o_run_len (run_len2), .o_alarm (alarm2)
  );

  function automatic int exp_bits(input bit [5:0] m);
`ifdef GUIA08_POPCOUNT_EN
    return $countones(m);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_run = 0; m_count = 0; m_count2 = 0;
    m_valid = 0; m_neq = 0; m_mask = '0; m_bits = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, leave time at edge+1.
  task automatic cycle(input bit v, input bit [5:0] a, input bit [5:0] b, input bit clr);
    bit acc;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; clear = clr;
    acc = v && !m_alarm;
    @(posedge clk);
    #1;
    in_valid = 0; clear = 0;
    if (clr) begin
      model_reset();
    end else if (acc) begin
      m_valid = 1;
      m_mask  = a ^ b;
      m_neq   = (a != b);
      m_bits  = exp_bits(a ^ b);
      if (m_neq) begin
        m_run    = (m_run < 15) ? m_run + 1 : 15;
        m_count  = (m_count < 255) ? m_count + 1 : 255;
        m_count2 = (m_count2 < 3) ? m_count2 + 1 : 3;
        if (m_run >= 3) m_alarm = 1;
      end else begin
        m_run = 0;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if ({neq_valid, neq, diff_mask, diff_bits, mcount, run_len, alarm} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got nv=%b neq=%b mask=%b bits=%0d cnt=%0d run=%0d alarm=%b rdy=%b, want all 0 rdy=1",
               neq_valid, neq, diff_mask, diff_bits, mcount, run_len, alarm, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, $urandom, $urandom, 0);
      checks++;
      if ({neq_valid, mcount, run_len, alarm} !== '0 || in_ready !== 1'b1 || dut.r_state !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got nv=%b cnt=%0d run=%0d alarm=%b rdy=%b st=%0d, want 0/0/0/0/1/IDLE",
                 i, neq_valid, mcount, run_len, alarm, in_ready, dut.r_state);
      end
    end
  endtask

  task automatic test_equal_pair();
    cycle(1, 6'b110110, 6'b110110, 0);
    checks++;
    if (neq_valid !== 1'b1 || neq !== 1'b0 || diff_mask !== 6'b0 || mcount !== 8'd0 || dut.r_state !== 2'd1) begin
      failures++;
      $display("FAIL equal_pair: got nv=%b neq=%b mask=%b cnt=%0d st=%0d, want 1/0/000000/0/MATCH",
               neq_valid, neq, diff_mask, mcount, dut.r_state);
    end
  endtask

  task automatic test_unequal_pair();
    cycle(1, 6'b110110, 6'b101010, 0);
    checks++;
    if (neq_valid !== 1'b1 || neq !== 1'b1 || diff_mask !== 6'b011100 || mcount !== 8'd1 ||
        run_len !== 4'd1 || diff_bits !== 3'(exp_bits(6'b011100))) begin
      failures++;
      $display("FAIL unequal_pair: got nv=%b neq=%b mask=%b cnt=%0d run=%0d bits=%0d, want 1/1/011100/1/1/%0d",
               neq_valid, neq, diff_mask, mcount, run_len, diff_bits, exp_bits(6'b011100));
    end
  endtask

  task automatic test_back_to_back_alarm();
    cycle(0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 6'(i), 6'(i) ^ 6'b100001, 0);
      checks++;
      if (neq_valid !== 1'b1 || run_len !== 4'(i) || mcount !== 8'(i) || alarm !== (i == 3)) begin
        failures++;
        $display("FAIL b2b_run[%0d]: got nv=%b run=%0d cnt=%0d alarm=%b, want 1/%0d/%0d/%0d",
                 i, neq_valid, run_len, mcount, alarm, i, i, (i == 3));
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL alarm_ready: got rdy=%b, want 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 6'h3F, 6'h00, 0);
      checks++;
      if (neq_valid !== 1'b0 || mcount !== 8'd3 || alarm !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL alarm_hold[%0d]: got nv=%b cnt=%0d alarm=%b rdy=%b, want 0/3/1/0",
                 i, neq_valid, mcount, alarm, in_ready);
      end
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (mcount !== 8'd0 || alarm !== 1'b0 || in_ready !== 1'b1 || run_len !== 4'd0) begin
      failures++;
      $display("FAIL alarm_clear: got cnt=%0d alarm=%b rdy=%b run=%0d, want 0/0/1/0",
               mcount, alarm, in_ready, run_len);
    end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 6'h15, 6'h2A, 0);
      cycle(1, 6'h0F, 6'h0F, 0);
      checks++;
      if (run_len2 !== 4'd0 || alarm2 !== 1'b0 || mcount2 !== 2'(m_count2)) begin
        failures++;
        $display("FAIL saturation[%0d]: got cnt2=%0d run2=%0d alarm2=%b, want %0d/0/0",
                 i, mcount2, run_len2, alarm2, m_count2);
      end
    end
    checks++;
    if (mcount2 !== 2'd3 || mcount !== 8'd5) begin
      failures++;
      $display("FAIL saturation_final: got cnt2=%0d cnt=%0d, want 3/5", mcount2, mcount);
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 6'h01, 6'h02, 0);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({neq_valid, neq, diff_mask, diff_bits, mcount, run_len, alarm} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got nv=%b cnt=%0d run=%0d alarm=%b rdy=%b, want 0/0/0/0/1",
               neq_valid, mcount, run_len, alarm, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_clear_with_transfer();
    cycle(1, 6'h11, 6'h22, 0);
    cycle(1, 6'h07, 6'h38, 1);
    checks++;
    if (neq_valid !== 1'b0 || mcount !== 8'd0 || run_len !== 4'd0 || neq !== 1'b0 ||
        diff_mask !== 6'd0 || in_ready !== 1'b1 || dut.r_state !== 2'd0) begin
      failures++;
      $display("FAIL clear_xfer: got nv=%b cnt=%0d run=%0d neq=%b mask=%b rdy=%b st=%0d, want 0/0/0/0/0/1/IDLE",
               neq_valid, mcount, run_len, neq, diff_mask, in_ready, dut.r_state);
    end
  endtask

  task automatic test_random();
    bit       v, clr;
    bit [5:0] a, b;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      a   = 6'($urandom);
      b   = ($urandom_range(0, 9) < 4) ? a : 6'($urandom);
      cycle(v, a, b, clr);
      checks++;
      if (neq_valid !== m_valid || neq !== m_neq || diff_mask !== m_mask || diff_bits !== 3'(m_bits) ||
          mcount !== 8'(m_count) || run_len !== 4'(m_run) || alarm !== m_alarm || in_ready !== !m_alarm ||
          neq_valid2 !== m_valid || neq2 !== m_neq || diff_mask2 !== m_mask || diff_bits2 !== 3'(m_bits) ||
          mcount2 !== 2'(m_count2) || run_len2 !== 4'(m_run) || alarm2 !== m_alarm || in_ready2 !== !m_alarm) begin
        failures++;
        $display("FAIL random[%0d]: got nv=%b neq=%b mask=%h bits=%0d cnt=%0d cnt2=%0d run=%0d alarm=%b rdy=%b, want %b/%b/%h/%0d/%0d/%0d/%0d/%b/%b",
                 i, neq_valid, neq, diff_mask, diff_bits, mcount, mcount2, run_len, alarm, in_ready,
                 m_valid, m_neq, m_mask, m_bits, m_count, m_count2, m_run, m_alarm, !m_alarm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal_pair();
    test_unequal_pair();
    test_back_to_back_alarm();
    test_saturation();
    test_async_reset();
    test_clear_with_transfer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
